// File: rtl/depth_pkg.sv
// Shared constants and reader state type for the depth frame readout path.
package depth_pkg;
  localparam int FRAME_PIXELS = 19200;
  localparam int ADDR_W       = 15;
  localparam int DATA_W       = 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } reader_state_e;
endpackage

// File: rtl/depth_skid_fifo.sv
// Two-entry FIFO holding {addr, data} pairs captured from the disparity buffer.
module depth_skid_fifo #(
  parameter int WIDTH = 23
) (
  input  logic             clk_data,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk_data) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign full      = (count_q == 2'd2);
  assign empty     = (count_q == 2'd0);
  assign count     = count_q;
endmodule

// File: rtl/depth_frame_reader.sv
// Streams one disparity frame from the buffer to a valid/ready consumer.
// Optional macro DEPTH_FRAME_AUTO_RESTART_EN: restart at addr 0 after each frame.
//
// state    | meaning
// ST_IDLE  | waiting for frame_start
// ST_READ  | issuing buffer reads 0..LAST_ADDR
// ST_DRAIN | all reads issued, emptying FIFO
module depth_frame_reader
  import depth_pkg::*;
(
  input  logic              clk_data,
  input  logic              rst_n,
  input  logic              frame_start,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              frame_done,
  output logic              busy
);
  reader_state_e            state_q, state_d;
  logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]        fly_addr_q, fly_addr_d;
  logic                     inflight_q, inflight_d;
  logic                     frame_done_q, frame_done_d;
  logic [ADDR_W+DATA_W-1:0] head;
  logic                     fifo_full, fifo_empty;
  logic [1:0]               fifo_count;
  logic                     pop, last_pop;
  logic [2:0]               occ;

  always_comb begin
    pop      = !fifo_empty && out_ready;
    last_pop = pop && (head[ADDR_W+DATA_W-1:DATA_W] == LAST_ADDR);
    // Slots already claimed, counting a read whose data lands next cycle.
    occ       = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
    ram_rd_en = (state_q == ST_READ) && (occ < 3'd2) && (!fifo_full || pop);

    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    inflight_d   = ram_rd_en;
    fly_addr_d   = ram_rd_en ? rd_addr_q : fly_addr_q;
    frame_done_d = last_pop;

    case (state_q)
      ST_IDLE: if (frame_start) state_d = ST_READ;
      ST_READ: begin
        if (ram_rd_en) begin
          if (rd_addr_q == LAST_ADDR) begin
            rd_addr_d = '0;
            state_d   = ST_DRAIN;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
          end
        end
      end
`ifdef DEPTH_FRAME_AUTO_RESTART_EN
      ST_DRAIN: if (last_pop) state_d = ST_READ;
`else
      ST_DRAIN: if (last_pop) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_data) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rd_addr_q    <= '0;
      fly_addr_q   <= '0;
      inflight_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      fly_addr_q   <= fly_addr_d;
      inflight_q   <= inflight_d;
      frame_done_q <= frame_done_d;
    end
  end

  depth_skid_fifo #(.WIDTH(ADDR_W + DATA_W)) u_fifo (
    .clk_data  (clk_data),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data ({fly_addr_q, ram_rdata}),
    .pop       (pop),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign ram_addr   = rd_addr_q;
  assign out_valid  = !fifo_empty;
  assign addr       = head[ADDR_W+DATA_W-1:DATA_W];
  assign data       = head[DATA_W-1:0];
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE);
endmodule

// File: doc/depth_frame_reader.md
DEPTH_FRAME_READER -- requirements
Module: depth_frame_reader

Interface
REQ-001 SHALL have port clk_data, input, 1 bit: the single clock, rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-003 SHALL have port frame_start, input, 1 bit: a one-cycle pulse that requests one frame readout.
REQ-004 SHALL have port ram_rd_en, output, 1 bit: disparity buffer read strobe.
REQ-005 SHALL have port ram_addr, output, 15 bits: disparity buffer read address.
REQ-006 SHALL have port ram_rdata, input, 8 bits: read data, valid exactly 1 cycle after ram_rd_en.
REQ-007 SHALL have port out_valid, output, 1 bit: a stream beat is present.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts the beat.
REQ-009 SHALL have port addr, output, 15 bits: pixel index of the beat, 0..19199.
REQ-010 SHALL have port data, output, 8 bits: disparity value of the beat.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of a frame.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, READ and DRAIN.
- IDLE->READ when frame_start=1.
- READ->DRAIN on the cycle read address 19199 is issued.
- DRAIN->IDLE on the cycle the beat with addr 19199 is accepted.
REQ-014 SHALL define a beat as accepted on any cycle where out_valid=1 and out_ready=1.
REQ-015 SHALL issue reads in increasing address order 0..19199, exactly once each per frame, with no wrap inside a frame.
REQ-016 SHALL capture ram_rdata into a 2-entry FIFO together with its address.
REQ-017 SHALL drive out_valid, addr and data from the FIFO head.
REQ-018 SHALL assert ram_rd_en only when (FIFO occupancy + reads in flight − pop this cycle) < 2, so the FIFO never overflows.
REQ-019 SHALL keep addr and data stable while out_valid=1 and out_ready=0.
REQ-020 SHALL never drop out_valid without an acceptance.
REQ-021 SHALL have the following latency: if frame_start is sampled at edge N, then ram_rd_en=1 with ram_addr=0 in cycle N+1, and out_valid=1 with addr=0 in cycle N+3.
REQ-022 SHALL sustain one beat per cycle while out_ready=1.
REQ-023 SHALL pulse frame_done high for exactly 1 cycle, in the cycle after addr 19199 is accepted.
REQ-024 SHALL ignore frame_start while busy=1; it is not queued.
REQ-025 SHALL give priority to the DRAIN->IDLE transition when frame_start coincides with the last acceptance; that frame_start is ignored.
REQ-026 SHALL compute ram_addr as 15-bit unsigned and compare terminal count against FRAME_PIXELS−1; values above 19199 never appear.

Reset
REQ-027 SHALL, with rst_n=0 at a clock edge, force the state to IDLE, empty the FIFO and clear the in-flight count.
REQ-028 SHALL, under that reset, drive ram_rd_en=0, ram_addr=0, out_valid=0, addr=0, data=0, frame_done=0 and busy=0 from the next cycle.
REQ-029 SHALL discard a partially read frame on reset, including in-flight RAM data.
REQ-030 SHALL start the next frame at addr 0.

Configuration
REQ-031 SHALL, with macro DEPTH_FRAME_AUTO_RESTART_EN defined, go DRAIN->READ instead of DRAIN->IDLE when the last beat is accepted.
- The next frame starts at addr 0 without frame_start.
- frame_done still pulses once per frame.
- busy stays 1 after the first frame_start.
REQ-032 SHALL, without DEPTH_FRAME_AUTO_RESTART_EN, read one frame per frame_start.

Structure
REQ-033 SHALL take the following from shared package depth_pkg: FRAME_PIXELS=19200, ADDR_W=15, DATA_W=8 and the reader state typedef.
REQ-034 SHALL implement the 2-entry FIFO as sub-module depth_skid_fifo (width ADDR_W+DATA_W, with push, pop, full, empty and count).

Verification
REQ-035 SHALL cover: RAM preloaded with data=addr[7:0], out_ready=1, frame_start at cycle 10 -> first beat addr 0/data 0 in cycle 13; 19200 contiguous beats; frame_done once in cycle 19213.
REQ-036 SHALL cover: out_ready alternating 1,0 -> every addr 0..19199 delivered once, in order; addr/data held on every stall cycle.
REQ-037 SHALL cover: out_ready=0 for 100 cycles after frame_start -> exactly 2 ram_rd_en pulses, then none; out_valid held with addr 0.
REQ-038 SHALL cover: frame_start re-pulsed at addr 5000 -> ignored; exactly one frame_done.
REQ-039 SHALL cover: rst_n=0 for 1 cycle at addr 5000 -> all outputs 0 in the next cycle; the following frame_start yields addr 0 first.
REQ-040 SHALL cover, with DEPTH_FRAME_AUTO_RESTART_EN: after addr 19199 is accepted, the next beat is addr 0 with no frame_start; frame_done pulses each frame.
